spi_tx_sequencer: RTL
=====================

// Module: spi_tx_sequencer
// PURPOSE
//  Upstream feeder for the byte-wide SPI transmitter (LOAD/BUSY/IN handshake). Buffers 9-bit
//  words {DC, byte} from the CPU/display-controller side in a FIFO and issues them one at a time.
//  Drives DCX to the panel, held stable for the whole byte. Keeps the SPI stage busy without
//  software polling, and reports overflow and handshake faults.
// PARAMETERS
//  DEPTH          16   FIFO entries, power of two, >=2
//  GAP_CYCLES     2    idle clocks inserted after BUSY falls before next LOAD (0 allowed)
//  START_TIMEOUT  8    max clocks in WAIT_START for SPI_BUSY to rise before fault
// PORTS
//  CLK_100MHz   in   1       system clock, all logic on rising edge
//  RESET_N      in   1       asynchronous, active-low reset
//  WR_EN        in   1       push WR_DATA when FULL=0; ignored (and flagged) when FULL=1
//  WR_DATA      in   9       [8]=DC (1 data, 0 command), [7:0]=byte, MSB-first on wire
//  FULL         out  1       FIFO holds DEPTH entries
//  EMPTY        out  1       FIFO holds 0 entries
//  LEVEL        out  AW+1    entry count 0..DEPTH, AW=$clog2(DEPTH)
//  OVERFLOW     out  1       sticky: WR_EN seen while FULL=1
//  FAULT        out  1       sticky: START_TIMEOUT expired
//  CLR_FLAGS    in   1       one-cycle pulse clears OVERFLOW and FAULT
//  IDLE         out  1       EMPTY=1 and state==S_IDLE and SPI_BUSY=0
//  BYTE_COUNT   out  16      bytes completed since reset, wraps 0xFFFF->0x0000
//  SPI_LOAD     out  1       one-cycle start pulse to SPI transmitter
//  SPI_IN       out  8       byte to SPI transmitter, valid while SPI_LOAD=1 and after
//  SPI_BUSY     in   1       SPI transmitter busy
//  DCX          out  1       panel data/command line
// BEHAVIOUR
//  Reset (async, RESET_N=0): FIFO emptied (pointers 0). EMPTY=1, FULL=0, LEVEL=0.
//   OVERFLOW=0, FAULT=0, SPI_LOAD=0, SPI_IN=0, DCX=0, BYTE_COUNT=0, state=S_IDLE.
//   Applies immediately mid-operation. The in-flight SPI byte is not aborted by this block.
//  FIFO: all outputs are registered. Write is accepted iff WR_EN=1 and FULL=0.
//   Write and pop on the same edge: LEVEL unchanged, both take effect. Pointers are AW bits
//   and wrap modulo DEPTH. A rejected write sets OVERFLOW and leaves contents unchanged.
//  CLR_FLAGS and a new overflow/fault on the same edge: the flag is set (set wins).
//  FSM (states S_IDLE, S_LOAD, S_WAIT_START, S_WAIT_DONE, S_GAP):
//   S_IDLE: if EMPTY=0 and SPI_BUSY=0, then on that edge:
//    - SPI_LOAD<=1, SPI_IN<=head[7:0], DCX<=head[8]
//    - pop head; ->S_LOAD
//   S_LOAD: SPI_LOAD<=0; timeout counter<=0; ->S_WAIT_START. LOAD is high exactly 1 clock.
//   S_WAIT_START: SPI_BUSY=1 -> S_WAIT_DONE. Otherwise increment the counter.
//    When the counter reaches START_TIMEOUT: FAULT<=1, ->S_IDLE (byte is lost, not retried).
//   S_WAIT_DONE: SPI_BUSY=0 -> BYTE_COUNT<=+1, gap counter<=0, then:
//    ->S_GAP if GAP_CYCLES>0, else ->S_IDLE.
//   S_GAP: count GAP_CYCLES clocks, then ->S_IDLE.
//   Illegal state encoding -> S_IDLE with SPI_LOAD=0.
//  SPI_IN and DCX change only on the S_IDLE->S_LOAD edge. Both are stable from LOAD until
//   the next issue, so DCX is valid across the whole SPI frame including CSX low.
//  Latency: a write into an empty FIFO with idle SPI gives SPI_LOAD=1 two edges later
//   (edge 1: write; edge 2: issue).
//  Back-to-back bytes: next SPI_LOAD occurs GAP_CYCLES+1 clocks after SPI_BUSY is seen low.
//  A write while the FSM is mid-transfer is buffered only and never disturbs SPI_IN/DCX.
// TESTING (bench includes the real SPI transmitter with a reduced SPI_FREQ for speed)
//  1. Push {1'b0,8'h2A} into an empty FIFO -> SPI_LOAD high exactly 1 clock, 2 edges later;
//     DCX=0; SCK/SDI shift 0x2A MSB-first; BYTE_COUNT=1; IDLE=1 afterwards.
//  2. Burst of 16 writes 0x100..0x10F with DEPTH=16 -> all 16 accepted, OVERFLOW=0.
//     Bytes appear on SDI in order with DCX=1, >=GAP_CYCLES idle clocks between CSX frames.
//     Write a 17th word while FULL=1 -> OVERFLOW=1 and it is never transmitted.
//  3. Simultaneous push and pop at LEVEL=5 -> LEVEL stays 5. Wrap pointers past DEPTH over
//     3 fills -> data order preserved.
//  4. Stub SPI_BUSY stuck 0 -> FAULT=1 after START_TIMEOUT (8) clocks in S_WAIT_START.
//     FSM returns to S_IDLE. CLR_FLAGS pulse -> FAULT=0.
//  5. Assert RESET_N=0 mid-byte with 4 entries queued -> LEVEL=0, EMPTY=1, SPI_LOAD=0,
//     DCX=0 immediately, with no clock edge required. After release, no spurious LOAD.
//  6. Force BYTE_COUNT to 0xFFFF (via 65535 transfers, or a fast model) -> next byte: 0x0000.

Source files
------------

// File: rtl/spi_tx_sequencer_if.sv
// Bundle between the word writer, the TX sequencer and the byte-wide SPI transmitter.
// Latency: none, wires only.
// Backpressure: FULL/OVERFLOW toward the writer; SPI_BUSY from the transmitter stalls issue.
// Ports: WR_EN/WR_DATA/CLR_FLAGS in; FULL/EMPTY/LEVEL/OVERFLOW/FAULT/IDLE/BYTE_COUNT out;
//        SPI_LOAD/SPI_IN/DCX out to the transmitter and panel; SPI_BUSY in.
interface spi_tx_sequencer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          WR_EN;
  logic [8:0]    WR_DATA;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   LEVEL;
  logic          OVERFLOW;
  logic          FAULT;
  logic          CLR_FLAGS;
  logic          IDLE;
  logic [15:0]   BYTE_COUNT;
  logic          SPI_LOAD;
  logic [7:0]    SPI_IN;
  logic          SPI_BUSY;
  logic          DCX;

  // slave: the sequencer itself
  modport slave (
    input  WR_EN, WR_DATA, CLR_FLAGS, SPI_BUSY,
    output FULL, EMPTY, LEVEL, OVERFLOW, FAULT, IDLE, BYTE_COUNT, SPI_LOAD, SPI_IN, DCX
  );

  // master: the side that writes words and hosts the SPI transmitter
  modport master (
    output WR_EN, WR_DATA, CLR_FLAGS, SPI_BUSY,
    input  FULL, EMPTY, LEVEL, OVERFLOW, FAULT, IDLE, BYTE_COUNT, SPI_LOAD, SPI_IN, DCX
  );
endinterface

// File: rtl/spi_tx_sequencer.sv
// Buffers {DC,byte} words in a FIFO and issues them one at a time to the SPI transmitter, driving DCX.
// Latency: write into empty FIFO with idle SPI -> SPI_LOAD two edges later; GAP_CYCLES+1 clocks between bytes.
// Backpressure: writes while FULL are dropped and flagged (OVERFLOW); SPI_BUSY holds issue.
// Ports: CLK_100MHz, RESET_N (async active-low), bus (slave modport of spi_tx_sequencer_if).
module spi_tx_sequencer #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic               CLK_100MHz,
  input  logic               RESET_N,
  spi_tx_sequencer_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_GAP        = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [8:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    level_q, level_d;
  logic           full_q, full_d, empty_q, empty_d;
  logic           overflow_q, overflow_d, fault_q, fault_d;
  logic           spi_load_q, spi_load_d;
  logic [7:0]     spi_in_q, spi_in_d;
  logic           dcx_q, dcx_d;
  logic [15:0]    byte_count_q, byte_count_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic           fault_set;

  logic       push, pop, to_expire, gap_done;
  logic [8:0] head;

  assign head      = mem_q[rd_ptr_q];
  assign push      = bus.WR_EN && !full_q;
  // Issue only when the transmitter is quiet, so a byte is never loaded into a busy shifter.
  assign pop       = (state_q == S_IDLE) && !empty_q && !bus.SPI_BUSY;
  assign to_expire = (32'(to_cnt_q) + 32'd1) >= START_TIMEOUT;
  assign gap_done  = (32'(gap_cnt_q) + 32'd1) >= GAP_CYCLES;

  // FIFO bookkeeping; flags are registered from the next level.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    full_d     = (level_d == (AW+1)'(DEPTH));
    empty_d    = (level_d == '0);
    // A new event in the same cycle as a clear keeps the flag set.
    overflow_d = (bus.WR_EN && full_q) || (overflow_q && !bus.CLR_FLAGS);
    fault_d    = fault_set || (fault_q && !bus.CLR_FLAGS);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (pop) state_d = S_LOAD;
      S_LOAD:       state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (bus.SPI_BUSY)   state_d = S_WAIT_DONE;
        else if (to_expire) state_d = S_IDLE;
      end
      S_WAIT_DONE:  if (!bus.SPI_BUSY) state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:        if (gap_done) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. SPI_IN and DCX move only on issue, so DCX stays valid for the frame.
  always_comb begin
    spi_load_d   = 1'b0;
    spi_in_d     = spi_in_q;
    dcx_d        = dcx_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    byte_count_d = byte_count_q;
    fault_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          spi_load_d = 1'b1;
          spi_in_d   = head[7:0];
          dcx_d      = head[8];
        end
      end
      S_LOAD: to_cnt_d = '0;
      S_WAIT_START: begin
        if (!bus.SPI_BUSY) begin
          if (to_expire) fault_set = 1'b1;   // byte dropped, no retry
          else           to_cnt_d  = to_cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.SPI_BUSY) begin
          byte_count_d = byte_count_q + 16'd1;
          gap_cnt_d    = '0;
        end
      end
      S_GAP:   if (!gap_done) gap_cnt_d = gap_cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      fault_q      <= 1'b0;
      spi_load_q   <= 1'b0;
      spi_in_q     <= '0;
      dcx_q        <= 1'b0;
      byte_count_q <= '0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_d;
      fault_q      <= fault_d;
      spi_load_q   <= spi_load_d;
      spi_in_q     <= spi_in_d;
      dcx_q        <= dcx_d;
      byte_count_q <= byte_count_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge CLK_100MHz) begin
    if (push) mem_q[wr_ptr_q] <= bus.WR_DATA;
  end

  assign bus.FULL       = full_q;
  assign bus.EMPTY      = empty_q;
  assign bus.LEVEL      = level_q;
  assign bus.OVERFLOW   = overflow_q;
  assign bus.FAULT      = fault_q;
  assign bus.SPI_LOAD   = spi_load_q;
  assign bus.SPI_IN     = spi_in_q;
  assign bus.DCX        = dcx_q;
  assign bus.BYTE_COUNT = byte_count_q;
  assign bus.IDLE       = empty_q && (state_q == S_IDLE) && !bus.SPI_BUSY;
endmodule
